// File: rtl/d_imm_pipe_pkg.sv
// Shared constants for the decode-stage immediate unit.
//   OPC_*  : RV base opcodes (inst[6:0]) recognised by the decoder.
//   IMM_*  : ImmSel encoding carried on out_imm_sel.
package d_imm_pipe_pkg;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_FENCE     = 7'b0001111;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] IMM_S     = 3'd0;
  localparam logic [2:0] IMM_B     = 3'd1;
  localparam logic [2:0] IMM_U     = 3'd2;
  localparam logic [2:0] IMM_J     = 3'd3;
  localparam logic [2:0] IMM_I     = 3'd4;
  localparam logic [2:0] IMM_SHAMT = 3'd5;
  localparam logic [2:0] IMM_CSR   = 3'd6;
  localparam logic [2:0] IMM_NONE  = 3'd7;

endpackage

// File: rtl/d_imm_pipe_imm_sel_decode.sv
// Combinational immediate-type decoder.
//   opcode_i  : inst[6:0]
//   funct3_i  : inst[14:12]
//   imm_sel_o : IMM_* immediate type
//   illegal_o : opcode not recognised (shamt width check is done by the caller,
//               since it depends on XLEN and inst[25])
module d_imm_pipe_imm_sel_decode
  import d_imm_pipe_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  output logic [2:0] imm_sel_o,
  output logic       illegal_o
);

  always_comb begin
    imm_sel_o = IMM_NONE;
    illegal_o = 1'b0;
    case (opcode_i)
      OPC_STORE:             imm_sel_o = IMM_S;
      OPC_BRANCH:            imm_sel_o = IMM_B;
      OPC_LUI, OPC_AUIPC:    imm_sel_o = IMM_U;
      OPC_JAL:               imm_sel_o = IMM_J;
      OPC_JALR, OPC_LOAD:    imm_sel_o = IMM_I;
      // funct3 001 (SLLI) and 101 (SRLI/SRAI) carry a shift amount
      OPC_ARI_ITYPE:         imm_sel_o = (funct3_i[1:0] == 2'b01) ? IMM_SHAMT : IMM_I;
      // CSR*I forms put a 5-bit zimm in the rs1 field
      OPC_SYSTEM:            imm_sel_o = funct3_i[2] ? IMM_CSR : IMM_I;
      OPC_ARI_RTYPE,
      OPC_FENCE:             imm_sel_o = IMM_NONE;
      default: begin
        imm_sel_o = IMM_NONE;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/d_imm_pipe.sv
// Decode-stage immediate unit: decodes the immediate type of an instruction and
// produces the extended immediate through a 1- or 2-stage valid/ready pipeline.
// Parameters: XLEN (32 or 64), STAGES (1 or 2), TAG_W (sideband width).
// Ports:
//   clk, reset       : clock, asynchronous active-high reset
//   flush            : drop all in-flight entries and this cycle's input
//   in_valid/in_ready: input handshake; in_inst instruction, in_tag sideband
//   out_valid/out_ready: output handshake
//   out_imm_sel      : IMM_* type, out_imm extended immediate
//   out_illegal      : unknown opcode or RV32 shift with inst[25] set
//   out_tag          : sideband carried unchanged
module d_imm_pipe
  import d_imm_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_imm_sel,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  // Every format is built at 64 bits and truncated, which keeps the
  // replication counts non-zero for both XLEN values.
  function automatic logic [XLEN-1:0] imm_ext(input logic [31:0] inst,
                                               input logic [2:0]  sel);
    logic [63:0] v;
    logic        s;
    s = inst[31];
    case (sel)
      IMM_I:     v = {{52{s}}, inst[31:20]};
      IMM_S:     v = {{52{s}}, inst[31:25], inst[11:7]};
      IMM_B:     v = {{51{s}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:     v = {{32{s}}, inst[31:12], 12'b0};
      IMM_J:     v = {{43{s}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_SHAMT: v = {58'b0, ((XLEN == 64) ? inst[25] : 1'b0), inst[24:20]};
      IMM_CSR:   v = {59'b0, inst[19:15]};
      default:   v = 64'b0;
    endcase
    return v[XLEN-1:0];
  endfunction

  logic [2:0] dec_sel;
  logic       dec_illegal;
  logic       in_illegal;
  logic       in_fire;

  d_imm_pipe_imm_sel_decode u_imm_sel_decode (
    .opcode_i  (in_inst[6:0]),
    .funct3_i  (in_inst[14:12]),
    .imm_sel_o (dec_sel),
    .illegal_o (dec_illegal)
  );

  // RV32 has only a 5-bit shift amount; bit 25 set would be a 6-bit shamt.
  assign in_illegal = dec_illegal |
                      ((XLEN == 32) && (dec_sel == IMM_SHAMT) && in_inst[25]);

  // A flushed cycle never captures, even if in_ready is high.
  assign in_fire = in_valid && in_ready && !flush;

  if (STAGES == 1) begin : g_one

    logic             v_q, v_d;
    logic [2:0]       sel_q;
    logic [XLEN-1:0]  imm_q;
    logic             ill_q;
    logic [TAG_W-1:0] tag_q;

    assign in_ready = !v_q || out_ready;

    always_comb begin
      v_d = v_q;
      if (flush)          v_d = 1'b0;
      else if (in_fire)   v_d = 1'b1;
      else if (out_ready) v_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q   <= 1'b0;
        sel_q <= IMM_NONE;
        imm_q <= '0;
        ill_q <= 1'b0;
        tag_q <= '0;
      end else begin
        v_q <= v_d;
        if (in_fire) begin
          sel_q <= dec_sel;
          imm_q <= imm_ext(in_inst, dec_sel);
          ill_q <= in_illegal;
          tag_q <= in_tag;
        end
      end
    end

    assign out_valid   = v_q;
    assign out_imm_sel = sel_q;
    assign out_imm     = imm_q;
    assign out_illegal = ill_q;
    assign out_tag     = tag_q;

  end else begin : g_two

    // Stage 1 holds the raw instruction and decode; stage 2 holds the immediate.
    logic             s1_v_q, s1_v_d;
    logic [31:0]      s1_inst_q;
    logic [2:0]       s1_sel_q;
    logic             s1_ill_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             s2_v_q, s2_v_d;
    logic [2:0]       s2_sel_q;
    logic [XLEN-1:0]  s2_imm_q;
    logic             s2_ill_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic             s2_load;
    logic             s2_load_en;

    assign s2_load    = s1_v_q && (!s2_v_q || out_ready);
    assign s2_load_en = s2_load && !flush;
    assign in_ready   = !s1_v_q || s2_load;

    always_comb begin
      s1_v_d = s1_v_q;
      if (flush)        s1_v_d = 1'b0;
      else if (in_fire) s1_v_d = 1'b1;
      else if (s2_load) s1_v_d = 1'b0;
    end

    always_comb begin
      s2_v_d = s2_v_q;
      if (flush)          s2_v_d = 1'b0;
      else if (s2_load)   s2_v_d = 1'b1;
      else if (out_ready) s2_v_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_v_q    <= 1'b0;
        s1_inst_q <= '0;
        s1_sel_q  <= IMM_NONE;
        s1_ill_q  <= 1'b0;
        s1_tag_q  <= '0;
      end else begin
        s1_v_q <= s1_v_d;
        if (in_fire) begin
          s1_inst_q <= in_inst;
          s1_sel_q  <= dec_sel;
          s1_ill_q  <= in_illegal;
          s1_tag_q  <= in_tag;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s2_v_q   <= 1'b0;
        s2_sel_q <= IMM_NONE;
        s2_imm_q <= '0;
        s2_ill_q <= 1'b0;
        s2_tag_q <= '0;
      end else begin
        s2_v_q <= s2_v_d;
        if (s2_load_en) begin
          s2_sel_q <= s1_sel_q;
          s2_imm_q <= imm_ext(s1_inst_q, s1_sel_q);
          s2_ill_q <= s1_ill_q;
          s2_tag_q <= s1_tag_q;
        end
      end
    end

    assign out_valid   = s2_v_q;
    assign out_imm_sel = s2_sel_q;
    assign out_imm     = s2_imm_q;
    assign out_illegal = s2_ill_q;
    assign out_tag     = s2_tag_q;

  end

endmodule
